// File: rtl/drum_env_vca.sv
// ----------------------------------------------------------------------------
// drum_env_vca
// Per-voice amplitude envelope and VCA for a drum voice. Each sample strobe
// scales the oscillator sample by an attack / exponential-decay envelope that
// a drum hit starts, and emits the shaped sample with a valid pulse.
//
// Parameters
//   THRESH        envelope level below which DECAY ends and the voice goes idle
// Ports
//   clk           system clock
//   rst           synchronous, active-high reset
//   sample_tick   one-cycle audio sample strobe (may repeat every cycle)
//   sin_sample    signed oscillator sample, read on sample_tick
//   trigger       one-cycle drum-hit pulse
//   velocity      hit strength, latched on trigger; 0 ignores the trigger
//   attack_step   envelope increment per tick in ATTACK; 0 = instant attack
//   decay_mult    Q0.16 per-tick decay factor
//   sample_out    signed shaped sample, valid two cycles after its tick
//   sample_valid  one-cycle pulse when sample_out updates
//   active        high while the envelope is not idle
// ----------------------------------------------------------------------------
module drum_env_vca #(
    parameter logic [15:0] THRESH = 16'd16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sample_tick,
    input  logic signed [15:0] sin_sample,
    input  logic               trigger,
    input  logic [6:0]         velocity,
    input  logic [15:0]        attack_step,
    input  logic [15:0]        decay_mult,
    output logic signed [15:0] sample_out,
    output logic               sample_valid,
    output logic               active
);

    typedef enum logic [1:0] {
        IDLE,
        ATTACK,
        DECAY
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] env_q, env_d;
    logic [15:0] tgt_q, tgt_d;

    // Pipeline: stage 1 holds the operands, stage 2 the product.
    logic               s1_valid_q;
    logic signed [15:0] s1_samp_q;
    logic [15:0]        s1_env_q;
    logic               s2_valid_q;
    logic signed [31:0] s2_prod_q;

    logic [15:0]        tgt_new;
    logic [16:0]        att_sum;
    logic [31:0]        decay_prod;
    logic [15:0]        decay_env;
    logic signed [31:0] samp_ext;
    logic signed [31:0] env_ext;
    logic signed [31:0] vca_prod;
    logic               unused_bits;

    assign tgt_new    = {velocity, 9'h1FF};
    // 17-bit sum so a large step cannot wrap past the target.
    assign att_sum    = {1'b0, env_q} + {1'b0, attack_step};
    assign decay_prod = {16'h0000, env_q} * {16'h0000, decay_mult};
    assign decay_env  = decay_prod[31:16];

    // |sample * env| < 2^31, so a 32-bit signed product is exact.
    assign samp_ext = 32'(s1_samp_q);
    assign env_ext  = $signed({16'h0000, s1_env_q});
    assign vca_prod = samp_ext * env_ext;

    assign unused_bits = ^{decay_prod[15:0], s2_prod_q[15:0]};

    always_comb begin
        state_d = state_q;
        env_d   = env_q;
        tgt_d   = tgt_q;
        if (trigger && (velocity != 7'd0)) begin
            // A hit overrides the tick's envelope step; env is kept on a
            // retrigger so the attack resumes from the current level.
            tgt_d = tgt_new;
            if (attack_step != 16'd0) begin
                state_d = ATTACK;
            end else begin
                state_d = DECAY;
                env_d   = tgt_new;
            end
        end else if (sample_tick) begin
            case (state_q)
                ATTACK: begin
                    // Also covers env above a lowered target after retrigger.
                    if (att_sum >= {1'b0, tgt_q}) begin
                        env_d   = tgt_q;
                        state_d = DECAY;
                    end else begin
                        env_d = att_sum[15:0];
                    end
                end
                DECAY: begin
                    if (decay_env < THRESH) begin
                        env_d   = '0;
                        state_d = IDLE;
                    end else begin
                        env_d = decay_env;
                    end
                end
                default: begin
                    env_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            env_q   <= '0;
            tgt_q   <= '0;
        end else begin
            state_q <= state_d;
            env_q   <= env_d;
            tgt_q   <= tgt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_samp_q  <= '0;
            s1_env_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_prod_q  <= '0;
        end else begin
            s1_valid_q <= sample_tick;
            if (sample_tick) begin
                s1_samp_q <= sin_sample;
                s1_env_q  <= env_q;
            end
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_prod_q <= vca_prod;
            end
        end
    end

    // Upper half of the product is the arithmetic >>>16 (floor toward -inf).
    assign sample_out   = s2_prod_q[31:16];
    assign sample_valid = s2_valid_q;
    assign active       = (state_q != IDLE);

endmodule

// File: tb/tb_drum_env_vca.sv
// ----------------------------------------------------------------------------
// tb_drum_env_vca
// Self-checking bench for drum_env_vca. A behavioural model tracks the
// envelope as plain integers and queues each tick's expected output with the
// cycle it is due; every scenario task compares the DUT against it.
// ----------------------------------------------------------------------------
module tb_drum_env_vca;

    logic               clk = 1'b0;
    logic               rst;
    logic               sample_tick;
    logic signed [15:0] sin_sample;
    logic               trigger;
    logic [6:0]         velocity;
    logic [15:0]        attack_step;
    logic [15:0]        decay_mult;
    logic signed [15:0] sample_out;
    logic               sample_valid;
    logic               active;

    always #5 clk = ~clk;

    drum_env_vca #(.THRESH(16'd16)) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_tick  (sample_tick),
        .sin_sample   (sin_sample),
        .trigger      (trigger),
        .velocity     (velocity),
        .attack_step  (attack_step),
        .decay_mult   (decay_mult),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .active       (active)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int          due;
        logic [15:0] val;
    } pend_t;

    pend_t       pq[$];
    int          cyc     = 0;
    int unsigned m_env   = 0;
    int unsigned m_tgt   = 0;
    string       m_phase = "idle";
    logic [15:0] m_out   = '0;
    logic        e_valid;
    logic [15:0] e_out;
    logic        e_active;

    // Drive one clock cycle and advance the reference model across the edge.
    task automatic drive_cycle(input logic r, input logic tk, input logic signed [15:0] sin,
                               input logic trg, input logic [6:0] vel);
        longint p;
        pend_t  e;
        pend_t  h;
        rst         = r;
        sample_tick = tk;
        sin_sample  = sin;
        trigger     = trg;
        velocity    = vel;
        @(posedge clk);
        if (r) begin
            pq.delete();
            m_env   = 0;
            m_tgt   = 0;
            m_phase = "idle";
            m_out   = '0;
        end else begin
            if (tk) begin
                p     = longint'(sin) * longint'(m_env);
                e.due = cyc + 2;
                e.val = 16'(p >>> 16);
                pq.push_back(e);
            end
            if (trg && vel != 0) begin
                m_tgt = int'(vel) * 512 + 511;
                if (attack_step != 0) m_phase = "attack";
                else begin
                    m_phase = "decay";
                    m_env   = m_tgt;
                end
            end else if (tk) begin
                if (m_phase == "attack") begin
                    m_env = (m_env + attack_step > m_tgt) ? m_tgt : m_env + attack_step;
                    if (m_env == m_tgt) m_phase = "decay";
                end else if (m_phase == "decay") begin
                    m_env = (m_env * decay_mult) / 65536;
                    if (m_env < 16) begin
                        m_env   = 0;
                        m_phase = "idle";
                    end
                end
            end
        end
        cyc = cyc + 1;
        #1;
        e_valid = 1'b0;
        if (pq.size() > 0 && pq[0].due == cyc) begin
            h       = pq.pop_front();
            e_valid = 1'b1;
            m_out   = h.val;
        end
        e_out    = m_out;
        e_active = (m_phase != "idle");
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) drive_cycle(1, 0, 16'sh0000, 0, 0);
        n_checks++;
        if (sample_out !== 16'sh0000 || sample_valid !== 1'b0 || active !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: out=%h valid=%b active=%b required 0000/0/0",
                     sample_out, sample_valid, active);
        end
        for (int t = 0; t < 5; t++) begin
            for (int k = 0; k < 4; k++) begin
                drive_cycle(0, k == 0, 16'sh7FFF, 0, 0);
                n_checks++;
                if (sample_valid !== e_valid || sample_out !== e_out || active !== 1'b0) begin
                    n_fail++;
                    $display("FAIL idle_ticks: valid=%b out=%h active=%b required %b/%h/0",
                             sample_valid, sample_out, active, e_valid, e_out);
                end
            end
        end
    endtask

    task automatic test_instant_decay();
        int nv = 0;
        attack_step = 16'h0000;
        decay_mult  = 16'h8000;
        drive_cycle(0, 0, 16'sh0000, 1, 7'd127);
        for (int t = 0; t < 16; t++) begin
            for (int k = 0; k < 2; k++) begin
                drive_cycle(0, k == 0, 16'sh7FFF, 0, 0);
                n_checks++;
                if (sample_valid !== e_valid || sample_out !== e_out || active !== e_active) begin
                    n_fail++;
                    $display("FAIL instant_decay: valid=%b out=%h active=%b required %b/%h/%b",
                             sample_valid, sample_out, active, e_valid, e_out, e_active);
                end
                if (sample_valid === 1'b1) begin
                    nv++;
                    if (nv == 1) begin
                        n_checks++;
                        if (sample_out !== 16'sh7FFE) begin
                            n_fail++;
                            $display("FAIL decay_first_out: got %h required 7ffe", sample_out);
                        end
                    end
                end
            end
        end
        n_checks++;
        if (active !== 1'b0) begin
            n_fail++;
            $display("FAIL decay_ends_idle: active=%b required 0", active);
        end
    endtask

    task automatic test_attack();
        int nv = 0;
        attack_step = 16'h1000;
        decay_mult  = 16'hF000;
        drive_cycle(0, 0, 16'sh0000, 1, 7'd64);
        for (int t = 0; t < 14; t++) begin
            drive_cycle(0, 1, -16'sd32768, 0, 0);
            n_checks++;
            if (sample_valid !== e_valid || sample_out !== e_out || active !== e_active) begin
                n_fail++;
                $display("FAIL attack_ramp: valid=%b out=%h active=%b required %b/%h/%b",
                         sample_valid, sample_out, active, e_valid, e_out, e_active);
            end
            if (sample_valid === 1'b1) begin
                nv++;
                if (nv == 2) begin
                    n_checks++;
                    if (sample_out !== 16'shF800) begin
                        n_fail++;
                        $display("FAIL attack_neg_floor: got %h required f800", sample_out);
                    end
                end
            end
        end
    endtask

    task automatic test_retrigger();
        attack_step = 16'h0000;
        decay_mult  = 16'h8000;
        drive_cycle(0, 0, 16'sh0000, 1, 7'd64);
        drive_cycle(0, 1, 16'sh4000, 0, 0);
        attack_step = 16'h2000;
        drive_cycle(0, 0, 16'sh0000, 1, 7'd127);
        for (int t = 0; t < 10; t++) begin
            drive_cycle(0, 1, 16'sh7FFF, 0, 0);
            n_checks++;
            if (sample_valid !== e_valid || sample_out !== e_out || active !== 1'b1) begin
                n_fail++;
                $display("FAIL retrigger: valid=%b out=%h active=%b required %b/%h/1",
                         sample_valid, sample_out, active, e_valid, e_out);
            end
        end
    endtask

    task automatic test_same_cycle();
        int nv = 0;
        drive_cycle(1, 0, 16'sh0000, 0, 0);
        attack_step = 16'h0000;
        decay_mult  = 16'hFF00;
        drive_cycle(0, 1, 16'sh7FFF, 1, 7'd100);
        for (int t = 0; t < 6; t++) begin
            drive_cycle(0, t % 2 == 0, 16'sh7FFF, 0, 0);
            n_checks++;
            if (sample_valid !== e_valid || sample_out !== e_out || active !== e_active) begin
                n_fail++;
                $display("FAIL same_cycle: valid=%b out=%h active=%b required %b/%h/%b",
                         sample_valid, sample_out, active, e_valid, e_out, e_active);
            end
            if (sample_valid === 1'b1) begin
                nv++;
                if (nv == 1) begin
                    n_checks++;
                    if (sample_out !== 16'sh0000) begin
                        n_fail++;
                        $display("FAIL same_cycle_first: got %h required 0000", sample_out);
                    end
                end
            end
        end
    endtask

    task automatic test_rst_mid();
        attack_step = 16'h0000;
        decay_mult  = 16'hFFFF;
        drive_cycle(0, 0, 16'sh0000, 1, 7'd127);
        drive_cycle(0, 1, 16'sh7FFF, 0, 0);
        drive_cycle(1, 0, 16'sh0000, 0, 0);
        for (int t = 0; t < 4; t++) begin
            drive_cycle(0, 0, 16'sh0000, 0, 0);
            n_checks++;
            if (sample_valid !== 1'b0 || sample_out !== 16'sh0000 || active !== 1'b0 ||
                e_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_mid: valid=%b out=%h active=%b required 0/0000/0",
                         sample_valid, sample_out, active);
            end
        end
    endtask

    task automatic test_back_to_back();
        attack_step = 16'h0000;
        decay_mult  = 16'hFFF0;
        drive_cycle(0, 0, 16'sh0000, 1, 7'd127);
        for (int t = 0; t < 12; t++) begin
            drive_cycle(0, t < 10, 16'(t * 3001 - 15000), 0, 0);
            n_checks++;
            if (sample_valid !== e_valid || sample_out !== e_out) begin
                n_fail++;
                $display("FAIL back_to_back: valid=%b out=%h required %b/%h",
                         sample_valid, sample_out, e_valid, e_out);
            end
        end
    endtask

    task automatic test_random();
        logic       tk;
        logic       trg;
        logic [6:0] vel;
        for (int t = 0; t < 500; t++) begin
            if ($urandom_range(0, 19) == 0) attack_step = ($urandom_range(0, 2) == 0) ? 16'h0000 : 16'($urandom);
            if ($urandom_range(0, 19) == 0) decay_mult = 16'($urandom_range(16'hE000, 16'hFFFF));
            tk  = ($urandom_range(0, 1) == 1);
            trg = ($urandom_range(0, 24) == 0);
            vel = ($urandom_range(0, 5) == 0) ? 7'd0 : 7'($urandom);
            drive_cycle($urandom_range(0, 299) == 0, tk, 16'($urandom), trg, vel);
            n_checks++;
            if (sample_valid !== e_valid || sample_out !== e_out || active !== e_active) begin
                n_fail++;
                $display("FAIL random[%0d]: valid=%b out=%h active=%b required %b/%h/%b",
                         t, sample_valid, sample_out, active, e_valid, e_out, e_active);
            end
        end
    endtask

    initial begin
        rst         = 1'b1;
        sample_tick = 1'b0;
        sin_sample  = '0;
        trigger     = 1'b0;
        velocity    = '0;
        attack_step = '0;
        decay_mult  = '0;
        test_reset();
        test_instant_decay();
        test_attack();
        test_retrigger();
        test_same_cycle();
        test_rst_mid();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
